mem_tag_remap: RTL and testbench
================================

Name: mem_tag_remap

Overview:
- Sits directly downstream of the memory request arbiter, between its merged request/response port and the memory interface.
- Compresses the wide arbiter tag (source tag plus inserted select bits) into a narrow slot index for read requests.
- Stores the original tag in a slot table, then restores it on the matching response so the arbiter's response demux sees the tag it issued.
- Bounds outstanding reads to NUM_SLOTS.

Parameters:
- NUM_SLOTS, 4, maximum outstanding reads; power of two, ≥2.
- DATA_WIDTH, 512, request/response data width in bits.
- ADDR_WIDTH, 26, request address width.
- TAG_IN_WIDTH, 8, tag width on the arbiter side.
- DATA_SIZE, DATA_WIDTH/8, byte-enable width.
- SLOT_BITS, CLOG2(NUM_SLOTS), memory-side tag width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req_valid_in  in  1  request valid from arbiter
- req_tag_in  in  TAG_IN_WIDTH  arbiter tag
- req_addr_in  in  ADDR_WIDTH  address
- req_rw_in  in  1  1=write, 0=read
- req_byteen_in  in  DATA_SIZE  byte enables
- req_data_in  in  DATA_WIDTH  write data
- req_ready_in  out  1  request accepted
- req_valid_out  out  1  request valid to memory
- req_tag_out  out  SLOT_BITS  slot index (0 for writes)
- req_addr_out  out  ADDR_WIDTH  forwarded address
- req_rw_out  out  1  forwarded rw
- req_byteen_out  out  DATA_SIZE  forwarded byte enables
- req_data_out  out  DATA_WIDTH  forwarded data
- req_ready_out  in  1  memory ready
- rsp_valid_in  in  1  memory response valid
- rsp_tag_in  in  SLOT_BITS  slot index of response
- rsp_data_in  in  DATA_WIDTH  response data
- rsp_ready_in  out  1  response accepted
- rsp_valid_out  out  1  response valid to arbiter
- rsp_tag_out  out  TAG_IN_WIDTH  restored arbiter tag
- rsp_data_out  out  DATA_WIDTH  response data
- rsp_ready_out  in  1  arbiter ready
- pending_count  out  CLOG2(NUM_SLOTS+1)  outstanding reads
- full  out  1  all slots allocated
- err_out  out  1  sticky protocol error

Behaviour:
- State:
  - valid_mask[NUM_SLOTS] and tag_table[NUM_SLOTS][TAG_IN_WIDTH] registers.
  - pending_count register.
  - err register.
- Reset:
  - valid_mask=0, pending_count=0, err_out=0; tag_table is not reset.
  - Consequently full=0, and every outputs-valid is 0 unless the corresponding valid_in is 1.
  - Reset mid-operation discards all pending slots; responses arriving afterwards are treated as unallocated.
- Request path is combinational, zero-latency pass-through. All fields are forwarded unchanged except the tag.
  - Read: req_valid_out = req_valid_in & ~full. req_ready_in = req_ready_out & ~full. req_tag_out = lowest-index clear bit of valid_mask.
  - Write: req_valid_out = req_valid_in. req_ready_in = req_ready_out. req_tag_out = 0. Writes allocate nothing and produce no response.
  - On read handshake (req_valid_in & req_ready_in & ~req_rw_in): set valid_mask[slot] and store tag_table[slot] = req_tag_in.
- Response path is combinational, zero-latency.
  - rsp_tag_out = tag_table[rsp_tag_in]; rsp_data_out = rsp_data_in.
  - rsp_valid_out = rsp_valid_in; rsp_ready_in = rsp_ready_out.
  - On response handshake: clear valid_mask[rsp_tag_in].
- Simultaneous allocate and free in one cycle:
  - Allocation selects from the pre-free mask, so the slot being freed is not reusable until the next cycle.
  - pending_count is unchanged net.
  - If full=1 and a free occurs, the read still stalls that cycle.
- pending_count: +1 on allocate, −1 on free, ±0 when both or neither occur; never wraps. full = (pending_count == NUM_SLOTS).
- No ordering requirement: responses may return in any slot order.

Optional Feature:
- Macro: MEM_TAG_REMAP_CHECK_EN.
- Defined:
  - A response whose slot has valid_mask clear is dropped: rsp_ready_in=1, rsp_valid_out=0.
  - err_out is set in the following cycle and holds until reset.
  - valid_mask and pending_count are unchanged by the dropped response.
- Undefined:
  - err_out is tied to 0.
  - The response is forwarded with the stale tag_table entry; the clear of an already-clear bit is harmless.
  - pending_count is decremented only if the bit was set.

Test Plan:
- NUM_SLOTS=4, TAG_IN_WIDTH=8, memory always ready. Reads with tags 0x11, 0x22, 0x33, 0x44 → req_tag_out 0,1,2,3; full=1; a fifth read (tag 0x55) sees req_ready_in=0 and req_valid_out=0.
- From full, respond slot 2 with data 0xAB → rsp_tag_out=0x33, rsp_data_out=0xAB, pending_count 4→3; the next read takes slot 2.
- Full, with response slot 0 and a read (tag 0x66) pending in the same cycle → response passes with tag 0x11; the read stalls that cycle, then issues next cycle with req_tag_out=0.
- Write (rw=1, tag 0x77) while full → forwarded with tag 0; pending_count unchanged.
- rsp_ready_out=0 for 3 cycles with response slot 1 valid → rsp_ready_in=0, slot 1 stays allocated; on release the tag is restored and the slot freed.
- With CHECK_EN, respond to slot 3 after reset → response dropped, rsp_valid_out=0, err_out=1 from the next cycle until reset.

Source files
------------

// File: rtl/mem_tag_remap.sv
// Read-tag compressor between the request arbiter and memory: wide arbiter tags are parked in a
// slot table and restored on response. Optional macro MEM_TAG_REMAP_CHECK_EN drops and flags unallocated responses.
module mem_tag_remap #(
  parameter int NUM_SLOTS    = 4,
  parameter int DATA_WIDTH   = 512,
  parameter int ADDR_WIDTH   = 26,
  parameter int TAG_IN_WIDTH = 8,
  parameter int DATA_SIZE    = DATA_WIDTH / 8,
  parameter int SLOT_BITS    = $clog2(NUM_SLOTS)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             req_valid_in,
  input  logic [TAG_IN_WIDTH-1:0]          req_tag_in,
  input  logic [ADDR_WIDTH-1:0]            req_addr_in,
  input  logic                             req_rw_in,
  input  logic [DATA_SIZE-1:0]             req_byteen_in,
  input  logic [DATA_WIDTH-1:0]            req_data_in,
  output logic                             req_ready_in,
  output logic                             req_valid_out,
  output logic [SLOT_BITS-1:0]             req_tag_out,
  output logic [ADDR_WIDTH-1:0]            req_addr_out,
  output logic                             req_rw_out,
  output logic [DATA_SIZE-1:0]             req_byteen_out,
  output logic [DATA_WIDTH-1:0]            req_data_out,
  input  logic                             req_ready_out,
  input  logic                             rsp_valid_in,
  input  logic [SLOT_BITS-1:0]             rsp_tag_in,
  input  logic [DATA_WIDTH-1:0]            rsp_data_in,
  output logic                             rsp_ready_in,
  output logic                             rsp_valid_out,
  output logic [TAG_IN_WIDTH-1:0]          rsp_tag_out,
  output logic [DATA_WIDTH-1:0]            rsp_data_out,
  input  logic                             rsp_ready_out,
  output logic [$clog2(NUM_SLOTS+1)-1:0]   pending_count,
  output logic                             full,
  output logic                             err_out
);

  localparam int CNT_W = $clog2(NUM_SLOTS + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(NUM_SLOTS);

  logic [NUM_SLOTS-1:0]    valid_mask;
  logic [TAG_IN_WIDTH-1:0] tag_table [NUM_SLOTS];

  logic [SLOT_BITS-1:0] alloc_slot;
  logic                 read_ok;
  logic                 alloc;
  logic                 slot_live;
  logic                 free;
  logic [NUM_SLOTS-1:0] alloc_vec;
  logic [NUM_SLOTS-1:0] free_vec;

  function automatic logic [SLOT_BITS-1:0] first_clear(input logic [NUM_SLOTS-1:0] mask);
    first_clear = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (!mask[i]) first_clear = SLOT_BITS'(i);
    end
  endfunction

  assign full       = (pending_count == FULL_CNT);
  assign alloc_slot = first_clear(valid_mask);

  // Request side: writes bypass the slot table entirely.
  assign read_ok        = req_rw_in | ~full;
  assign req_valid_out  = req_valid_in & read_ok;
  assign req_ready_in   = req_ready_out & read_ok;
  assign req_tag_out    = req_rw_in ? '0 : alloc_slot;
  assign req_addr_out   = req_addr_in;
  assign req_rw_out     = req_rw_in;
  assign req_byteen_out = req_byteen_in;
  assign req_data_out   = req_data_in;
  assign alloc          = req_valid_in & req_ready_in & ~req_rw_in;

  assign slot_live    = valid_mask[rsp_tag_in];
  assign rsp_tag_out  = tag_table[rsp_tag_in];
  assign rsp_data_out = rsp_data_in;

`ifdef MEM_TAG_REMAP_CHECK_EN
  logic err_q;

  // Unallocated responses are swallowed so they never reach the arbiter demux.
  assign rsp_valid_out = rsp_valid_in & slot_live;
  assign rsp_ready_in  = slot_live ? rsp_ready_out : 1'b1;
  assign err_out       = err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if (rsp_valid_in & ~slot_live) begin
      err_q <= 1'b1;
    end
  end
`else
  assign rsp_valid_out = rsp_valid_in;
  assign rsp_ready_in  = rsp_ready_out;
  assign err_out       = 1'b0;
`endif

  assign free = rsp_valid_in & rsp_ready_in & slot_live;

  always_comb begin
    alloc_vec = '0;
    free_vec  = '0;
    if (alloc) alloc_vec[alloc_slot] = 1'b1;
    if (free)  free_vec[rsp_tag_in]  = 1'b1;
  end

  // Allocation was chosen from the pre-free mask, so set and clear never target the same slot.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_mask    <= '0;
      pending_count <= '0;
    end else begin
      valid_mask <= (valid_mask & ~free_vec) | alloc_vec;
      case ({alloc, free})
        2'b10:   pending_count <= pending_count + CNT_W'(1);
        2'b01:   pending_count <= pending_count - CNT_W'(1);
        default: pending_count <= pending_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (alloc) tag_table[alloc_slot] <= req_tag_in;
  end

endmodule

// File: tb/tb_mem_tag_remap.sv
// Directed bench for mem_tag_remap with NUM_SLOTS=4 and TAG_IN_WIDTH=8; memory side ready unless a test stalls it.
module tb_mem_tag_remap;

  localparam int NS = 4;
  localparam int DW = 512;
  localparam int AW = 26;
  localparam int TW = 8;
  localparam int BW = DW / 8;
  localparam int SB = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid_in;
  logic [TW-1:0] req_tag_in;
  logic [AW-1:0] req_addr_in;
  logic          req_rw_in;
  logic [BW-1:0] req_byteen_in;
  logic [DW-1:0] req_data_in;
  logic          req_ready_in;
  logic          req_valid_out;
  logic [SB-1:0] req_tag_out;
  logic [AW-1:0] req_addr_out;
  logic          req_rw_out;
  logic [BW-1:0] req_byteen_out;
  logic [DW-1:0] req_data_out;
  logic          req_ready_out;
  logic          rsp_valid_in;
  logic [SB-1:0] rsp_tag_in;
  logic [DW-1:0] rsp_data_in;
  logic          rsp_ready_in;
  logic          rsp_valid_out;
  logic [TW-1:0] rsp_tag_out;
  logic [DW-1:0] rsp_data_out;
  logic          rsp_ready_out;
  logic [2:0]    pending_count;
  logic          full;
  logic          err_out;

  int n_cmp = 0;
  int n_err = 0;

  mem_tag_remap #(.NUM_SLOTS(NS), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TAG_IN_WIDTH(TW)) dut (
    .clk(clk), .reset(reset),
    .req_valid_in(req_valid_in), .req_tag_in(req_tag_in), .req_addr_in(req_addr_in),
    .req_rw_in(req_rw_in), .req_byteen_in(req_byteen_in), .req_data_in(req_data_in),
    .req_ready_in(req_ready_in), .req_valid_out(req_valid_out), .req_tag_out(req_tag_out),
    .req_addr_out(req_addr_out), .req_rw_out(req_rw_out), .req_byteen_out(req_byteen_out),
    .req_data_out(req_data_out), .req_ready_out(req_ready_out),
    .rsp_valid_in(rsp_valid_in), .rsp_tag_in(rsp_tag_in), .rsp_data_in(rsp_data_in),
    .rsp_ready_in(rsp_ready_in), .rsp_valid_out(rsp_valid_out), .rsp_tag_out(rsp_tag_out),
    .rsp_data_out(rsp_data_out), .rsp_ready_out(rsp_ready_out),
    .pending_count(pending_count), .full(full), .err_out(err_out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req_valid_in  = 1'b0;
    req_tag_in    = '0;
    req_addr_in   = '0;
    req_rw_in     = 1'b0;
    req_byteen_in = '0;
    req_data_in   = '0;
    req_ready_out = 1'b1;
    rsp_valid_in  = 1'b0;
    rsp_tag_in    = '0;
    rsp_data_in   = '0;
    rsp_ready_out = 1'b1;
  endtask

  task automatic drive_read(input logic [TW-1:0] tag);
    req_valid_in = 1'b1;
    req_rw_in    = 1'b0;
    req_tag_in   = tag;
    req_addr_in  = AW'(32'h0100 + 32'(tag));
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    idle();
    apply_reset();
    n_cmp++; if (pending_count !== 3'd0) begin n_err++; $display("FAIL reset_pending: got %0d expected 0", pending_count); end
    n_cmp++; if (full !== 1'b0) begin n_err++; $display("FAIL reset_full: got %b expected 0", full); end
    n_cmp++; if (err_out !== 1'b0) begin n_err++; $display("FAIL reset_err: got %b expected 0", err_out); end
    n_cmp++; if (req_valid_out !== 1'b0 || rsp_valid_out !== 1'b0) begin n_err++; $display("FAIL reset_valids: got req %b rsp %b expected 0 0", req_valid_out, rsp_valid_out); end
  endtask

  task automatic test_fill();
    logic [TW-1:0] tags [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) begin
      drive_read(tags[i]);
      #1;
      n_cmp++; if (req_tag_out !== SB'(i)) begin n_err++; $display("FAIL fill_slot%0d: got %0d expected %0d", i, req_tag_out, i); end
      n_cmp++; if (req_ready_in !== 1'b1 || req_valid_out !== 1'b1) begin n_err++; $display("FAIL fill_hs%0d: got ready %b valid %b expected 1 1", i, req_ready_in, req_valid_out); end
      n_cmp++; if (req_addr_out !== AW'(32'h0100 + 32'(tags[i]))) begin n_err++; $display("FAIL fill_addr%0d: got %h expected %h", i, req_addr_out, AW'(32'h0100 + 32'(tags[i]))); end
      tick();
      n_cmp++; if (pending_count !== 3'(i + 1)) begin n_err++; $display("FAIL fill_count%0d: got %0d expected %0d", i, pending_count, i + 1); end
    end
    n_cmp++; if (full !== 1'b1) begin n_err++; $display("FAIL fill_full: got %b expected 1", full); end
    drive_read(8'h55);
    #1;
    n_cmp++; if (req_ready_in !== 1'b0 || req_valid_out !== 1'b0) begin n_err++; $display("FAIL fifth_read_stall: got ready %b valid %b expected 0 0", req_ready_in, req_valid_out); end
    tick();
    n_cmp++; if (pending_count !== 3'd4) begin n_err++; $display("FAIL fifth_read_count: got %0d expected 4", pending_count); end
    idle();
  endtask

  // Table afterwards: 0=0x11 1=0x22 2=0x5A 3=0x44
  task automatic test_response_free();
    rsp_valid_in = 1'b1;
    rsp_tag_in   = 2'd2;
    rsp_data_in  = DW'(8'hAB);
    #1;
    n_cmp++; if (rsp_tag_out !== 8'h33) begin n_err++; $display("FAIL rsp2_tag: got %h expected 33", rsp_tag_out); end
    n_cmp++; if (rsp_data_out !== DW'(8'hAB)) begin n_err++; $display("FAIL rsp2_data: got %h expected ab", rsp_data_out[31:0]); end
    n_cmp++; if (rsp_valid_out !== 1'b1 || rsp_ready_in !== 1'b1) begin n_err++; $display("FAIL rsp2_hs: got valid %b ready %b expected 1 1", rsp_valid_out, rsp_ready_in); end
    tick();
    idle();
    n_cmp++; if (pending_count !== 3'd3 || full !== 1'b0) begin n_err++; $display("FAIL rsp2_count: got %0d full %b expected 3 0", pending_count, full); end
    drive_read(8'h5A);
    #1;
    n_cmp++; if (req_tag_out !== 2'd2) begin n_err++; $display("FAIL refill_slot: got %0d expected 2", req_tag_out); end
    tick();
    idle();
    n_cmp++; if (pending_count !== 3'd4) begin n_err++; $display("FAIL refill_count: got %0d expected 4", pending_count); end
  endtask

  // Table afterwards: slot 0 = 0x66
  task automatic test_simultaneous_full();
    rsp_valid_in = 1'b1;
    rsp_tag_in   = 2'd0;
    drive_read(8'h66);
    #1;
    n_cmp++; if (rsp_tag_out !== 8'h11 || rsp_valid_out !== 1'b1) begin n_err++; $display("FAIL simul_rsp: got tag %h valid %b expected 11 1", rsp_tag_out, rsp_valid_out); end
    n_cmp++; if (req_ready_in !== 1'b0 || req_valid_out !== 1'b0) begin n_err++; $display("FAIL simul_stall: got ready %b valid %b expected 0 0", req_ready_in, req_valid_out); end
    tick();
    rsp_valid_in = 1'b0;
    n_cmp++; if (pending_count !== 3'd3) begin n_err++; $display("FAIL simul_count: got %0d expected 3", pending_count); end
    #1;
    n_cmp++; if (req_tag_out !== 2'd0 || req_ready_in !== 1'b1) begin n_err++; $display("FAIL simul_retry: got slot %0d ready %b expected 0 1", req_tag_out, req_ready_in); end
    tick();
    idle();
    n_cmp++; if (pending_count !== 3'd4) begin n_err++; $display("FAIL simul_retry_count: got %0d expected 4", pending_count); end
  endtask

  task automatic test_write();
    req_valid_in  = 1'b1;
    req_rw_in     = 1'b1;
    req_tag_in    = 8'h77;
    req_byteen_in = BW'(16'hF00F);
    req_data_in   = DW'(32'hDEADBEEF);
    #1;
    n_cmp++; if (req_valid_out !== 1'b1 || req_ready_in !== 1'b1 || req_tag_out !== 2'd0) begin n_err++; $display("FAIL write_full: got valid %b ready %b tag %0d expected 1 1 0", req_valid_out, req_ready_in, req_tag_out); end
    n_cmp++; if (req_rw_out !== 1'b1 || req_byteen_out !== BW'(16'hF00F) || req_data_out !== DW'(32'hDEADBEEF)) begin n_err++; $display("FAIL write_fwd: got rw %b be %h data %h expected 1 f00f deadbeef", req_rw_out, req_byteen_out[15:0], req_data_out[31:0]); end
    req_ready_out = 1'b0;
    #1;
    n_cmp++; if (req_ready_in !== 1'b0) begin n_err++; $display("FAIL write_bp: got %b expected 0", req_ready_in); end
    req_ready_out = 1'b1;
    tick();
    idle();
    n_cmp++; if (pending_count !== 3'd4) begin n_err++; $display("FAIL write_count: got %0d expected 4", pending_count); end
  endtask

  task automatic test_backpressure();
    rsp_valid_in  = 1'b1;
    rsp_tag_in    = 2'd1;
    rsp_ready_out = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_cmp++; if (rsp_ready_in !== 1'b0 || rsp_valid_out !== 1'b1) begin n_err++; $display("FAIL bp_hold%0d: got ready %b valid %b expected 0 1", c, rsp_ready_in, rsp_valid_out); end
      tick();
      n_cmp++; if (pending_count !== 3'd4) begin n_err++; $display("FAIL bp_count%0d: got %0d expected 4", c, pending_count); end
    end
    rsp_ready_out = 1'b1;
    #1;
    n_cmp++; if (rsp_ready_in !== 1'b1 || rsp_tag_out !== 8'h22) begin n_err++; $display("FAIL bp_release: got ready %b tag %h expected 1 22", rsp_ready_in, rsp_tag_out); end
    tick();
    idle();
    n_cmp++; if (pending_count !== 3'd3) begin n_err++; $display("FAIL bp_freed: got %0d expected 3", pending_count); end
  endtask

  // Slot 1 free; free slot 0 while reading: the read must take slot 1 (pre-free mask).
  task automatic test_back_to_back();
    rsp_valid_in = 1'b1;
    rsp_tag_in   = 2'd0;
    drive_read(8'h88);
    #1;
    n_cmp++; if (req_tag_out !== 2'd1 || req_ready_in !== 1'b1) begin n_err++; $display("FAIL b2b_slot: got %0d ready %b expected 1 1", req_tag_out, req_ready_in); end
    n_cmp++; if (rsp_tag_out !== 8'h66) begin n_err++; $display("FAIL b2b_rsp_tag: got %h expected 66", rsp_tag_out); end
    tick();
    rsp_valid_in = 1'b0;
    n_cmp++; if (pending_count !== 3'd3) begin n_err++; $display("FAIL b2b_net_count: got %0d expected 3", pending_count); end
    drive_read(8'h99);
    #1;
    n_cmp++; if (req_tag_out !== 2'd0) begin n_err++; $display("FAIL b2b_next_slot: got %0d expected 0", req_tag_out); end
    tick();
    idle();
    rsp_valid_in = 1'b1;
    rsp_tag_in   = 2'd1;
    #1;
    n_cmp++; if (rsp_tag_out !== 8'h88) begin n_err++; $display("FAIL b2b_stored_tag: got %h expected 88", rsp_tag_out); end
    idle();
    n_cmp++; if (full !== 1'b1) begin n_err++; $display("FAIL b2b_full: got %b expected 1", full); end
  endtask

  task automatic test_unallocated();
    apply_reset();
    n_cmp++; if (pending_count !== 3'd0 || full !== 1'b0) begin n_err++; $display("FAIL midreset: got %0d full %b expected 0 0", pending_count, full); end
    rsp_valid_in = 1'b1;
    rsp_tag_in   = 2'd3;
    #1;
`ifdef MEM_TAG_REMAP_CHECK_EN
    n_cmp++; if (rsp_valid_out !== 1'b0 || rsp_ready_in !== 1'b1) begin n_err++; $display("FAIL drop_hs: got valid %b ready %b expected 0 1", rsp_valid_out, rsp_ready_in); end
    n_cmp++; if (err_out !== 1'b0) begin n_err++; $display("FAIL drop_err_early: got %b expected 0", err_out); end
    tick();
    idle();
    for (int c = 0; c < 3; c++) begin
      n_cmp++; if (err_out !== 1'b1) begin n_err++; $display("FAIL drop_err_sticky%0d: got %b expected 1", c, err_out); end
      tick();
    end
    n_cmp++; if (pending_count !== 3'd0) begin n_err++; $display("FAIL drop_count: got %0d expected 0", pending_count); end
    apply_reset();
    n_cmp++; if (err_out !== 1'b0) begin n_err++; $display("FAIL drop_err_clear: got %b expected 0", err_out); end
`else
    n_cmp++; if (rsp_valid_out !== 1'b1 || rsp_tag_out !== 8'h44) begin n_err++; $display("FAIL stale_fwd: got valid %b tag %h expected 1 44", rsp_valid_out, rsp_tag_out); end
    tick();
    idle();
    n_cmp++; if (pending_count !== 3'd0 || err_out !== 1'b0) begin n_err++; $display("FAIL stale_count: got %0d err %b expected 0 0", pending_count, err_out); end
    drive_read(8'hC3);
    #1;
    n_cmp++; if (req_tag_out !== 2'd0) begin n_err++; $display("FAIL stale_alloc: got %0d expected 0", req_tag_out); end
    tick();
    idle();
    n_cmp++; if (pending_count !== 3'd1) begin n_err++; $display("FAIL stale_alloc_count: got %0d expected 1", pending_count); end
`endif
  endtask

  initial begin
    reset = 1'b1;
    idle();
    test_reset();
    test_fill();
    test_response_free();
    test_simultaneous_full();
    test_write();
    test_backpressure();
    test_back_to_back();
    test_unallocated();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
